// File: rtl/cnt_ctrl.sv
// rtl/cnt_ctrl.sv - run controller sequencing load/enable of the lab counter and detecting its terminal value
module cnt_ctrl #(
  parameter int WIDTH = 5,
  parameter int GUARD = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] preset,
  input  logic [WIDTH-1:0] term,
  input  logic [WIDTH-1:0] cnt_val,
  output logic             enab,
  output logic             load,
  output logic [WIDTH-1:0] cnt_in,
  output logic             busy,
  output logic             done,
  output logic [7:0]       reloads
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

  localparam logic [3:0] GUARD_INIT = 4'(GUARD);

  state_t           state;
  state_t           state_nx;
  logic [3:0]       guard;
  logic [WIDTH-1:0] term_r;
  logic             accept;
  logic             advance;
  logic             match;

  assign accept  = (state == IDLE) && start && !stop;
  // RUN cycles not pre-empted by stop or pause: these are the only ones that age the guard or compare
  assign advance = (state == RUN) && !stop && !pause;
  assign match   = advance && (guard == 4'd0) && (cnt_val == term_r);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = LOAD;
      LOAD: state_nx = stop ? IDLE : RUN;
      RUN: begin
        if (stop) begin
          state_nx = IDLE;
        end else if (pause) begin
          state_nx = HOLD;
        end else if (match) begin
          state_nx = auto_reload ? LOAD : IDLE;
        end
      end
      HOLD: begin
        if (stop) begin
          state_nx = IDLE;
        end else if (!pause) begin
          state_nx = RUN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    enab = 1'b0;
    load = 1'b0;
    case (state)
      LOAD: begin
        enab = 1'b1;
        load = 1'b1;
      end
      RUN:     enab = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      guard   <= 4'd0;
      term_r  <= '0;
      cnt_in  <= '0;
      reloads <= 8'd0;
      done    <= 1'b0;
    end else begin
      done <= match;
      if (accept) begin
        cnt_in  <= preset;
        term_r  <= term;
        reloads <= 8'd0;
      end
      if (match && auto_reload && (reloads != 8'hff)) begin
        reloads <= reloads + 8'd1;
      end
      // Re-arm the guard on every entry to RUN so the counter output can settle after load/resume
      if ((state_nx == RUN) && (state != RUN)) begin
        guard <= GUARD_INIT;
      end else if (advance && (guard != 4'd0)) begin
        guard <= guard - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_cnt_ctrl.sv
// tb/tb_cnt_ctrl.sv - directed scoreboard bench for cnt_ctrl
module tb_cnt_ctrl;

  localparam int WIDTH = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic             pause;
  logic             auto_reload;
  logic [WIDTH-1:0] preset;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] cnt_val;
  logic             enab;
  logic             load;
  logic [WIDTH-1:0] cnt_in;
  logic             busy;
  logic             done;
  logic [7:0]       reloads;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int k;
  int exp_q[$];

  cnt_ctrl #(.WIDTH(WIDTH), .GUARD(2)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .auto_reload(auto_reload), .preset(preset), .term(term), .cnt_val(cnt_val),
    .enab(enab), .load(load), .cnt_in(cnt_in), .busy(busy), .done(done),
    .reloads(reloads)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected done cycles are queued at start; each observed pulse pops one
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0] < cyc) begin
      chk("done_missing", 32'(cyc), 32'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("done_unexpected", {31'd0, done}, 32'd0);
      end else begin
        chk("done_cycle", 32'(cyc), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b1; pause = 1'b1; stop = 1'b0; auto_reload = 1'b0;
    preset = '0; term = '0; cnt_val = '0;

    repeat (2) begin
      @(negedge clk);
      chk("rst_enab", {31'd0, enab}, 32'd0);
      chk("rst_load", {31'd0, load}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_cnt_in", 32'(cnt_in), 32'd0);
      chk("rst_reloads", 32'(reloads), 32'd0);
    end
    rst = 1'b0; start = 1'b0; pause = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // one-shot
    preset = 5'd3; term = 5'd7; start = 1'b1; k = cyc + 1;
    exp_q.push_back(k + 4);
    @(negedge clk);
    start = 1'b0;
    chk("os_load", {31'd0, load}, 32'd1);
    chk("os_cnt_in", 32'(cnt_in), 32'd3);
    chk("os_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("os_load_once", {31'd0, load}, 32'd0);
    chk("os_enab_run", {31'd0, enab}, 32'd1);
    @(negedge clk);
    cnt_val = 5'd7;
    @(negedge clk);
    chk("os_guard_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("os_done", {31'd0, done}, 32'd1);
    chk("os_end_enab", {31'd0, enab}, 32'd0);
    chk("os_end_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("os_done_once", {31'd0, done}, 32'd0);

    // auto-reload, three matches, preset changed mid-run
    auto_reload = 1'b1; start = 1'b1; k = cyc + 1;
    exp_q.push_back(k + 4); exp_q.push_back(k + 8); exp_q.push_back(k + 12);
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start = 1'b0;
        preset = 5'd9;
      end
      chk("ar_load", {31'd0, load}, {31'd0, (i % 4) == 0});
      chk("ar_cnt_in", 32'(cnt_in), 32'd3);
      chk("ar_reloads", 32'(reloads), 32'(i / 4));
    end

    // priority: start ignored in RUN, then stop+pause+match together
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("pri_start_load", {31'd0, load}, 32'd0);
    chk("pri_start_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    stop = 1'b1; pause = 1'b1;
    @(negedge clk);
    stop = 1'b0; pause = 1'b0; auto_reload = 1'b0;
    chk("pri_busy", {31'd0, busy}, 32'd0);
    chk("pri_enab", {31'd0, enab}, 32'd0);
    chk("pri_done", {31'd0, done}, 32'd0);
    chk("pri_reloads", 32'(reloads), 32'd3);

    // pause with term=0
    preset = 5'd1; term = 5'd0; cnt_val = 5'd5; start = 1'b1; k = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    pause = 1'b1;
    @(negedge clk);
    cnt_val = 5'd0;
    chk("pz_enab", {31'd0, enab}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("pz_hold_enab", {31'd0, enab}, 32'd0);
      chk("pz_hold_busy", {31'd0, busy}, 32'd1);
    end
    pause = 1'b0;
    exp_q.push_back(cyc + 4);
    @(negedge clk);
    chk("pz_resume_enab", {31'd0, enab}, 32'd1);
    repeat (2) begin
      @(negedge clk);
      chk("pz_guard_busy", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    chk("pz_done", {31'd0, done}, 32'd1);
    chk("pz_end_busy", {31'd0, busy}, 32'd0);

    // reset mid-run with five reloads
    preset = 5'd6; term = 5'd11; cnt_val = 5'd11; auto_reload = 1'b1; start = 1'b1; k = cyc + 1;
    for (int i = 1; i <= 5; i++) exp_q.push_back(k + 4 * i);
    @(negedge clk);
    start = 1'b0;
    repeat (21) @(negedge clk);
    chk("mr_reloads", 32'(reloads), 32'd5);
    chk("mr_cnt_in", 32'(cnt_in), 32'd6);
    chk("mr_enab", {31'd0, enab}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; auto_reload = 1'b0; cnt_val = '0;
    chk("mr_rst_busy", {31'd0, busy}, 32'd0);
    chk("mr_rst_enab", {31'd0, enab}, 32'd0);
    chk("mr_rst_load", {31'd0, load}, 32'd0);
    chk("mr_rst_cnt_in", 32'(cnt_in), 32'd0);
    chk("mr_rst_reloads", 32'(reloads), 32'd0);

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
